// File: rtl/multicycle_controller_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the RV32I multi-cycle controller:
//   - RV32I major opcode constants recognised by the controller
//   - controller state enum (3 bits)
//   - datapath select encodings for alu_src_a, alu_op and wb_sel
//   - is_legal_opcode(): the set of opcodes this core executes
// ---------------------------------------------------------------------------
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    // alu_src_a encodings
    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    // alu_op encodings
    localparam logic [1:0] ALU_OP_ADD  = 2'd0;
    localparam logic [1:0] ALU_OP_FUNC = 2'd1;
    localparam logic [1:0] ALU_OP_CMP  = 2'd2;

    // wb_sel encodings
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_R, OP_LOAD, OP_IMM, OP_STORE,
            OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// ctrl_bus_if
// Memory handshake bundle between the controller and the instruction/data
// memories.
//   imem_req   : instruction fetch request        (controller -> memory)
//   imem_ready : instruction data valid           (memory -> controller)
//   dmem_req   : data access request              (controller -> memory)
//   dmem_we    : data access is a write           (controller -> memory)
//   dmem_ready : data access complete             (memory -> controller)
// Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface ctrl_bus_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_controller_wait_timer.sv
// ---------------------------------------------------------------------------
// ctrl_wait_timer
// Counts memory wait cycles for the controller.
//   clk     : core clock
//   reset   : synchronous active-high, clears the count
//   clear   : clears the count (controller changes state)
//   count   : a wait cycle is in progress (ready low in FETCH/MEM)
//   expired : this wait cycle is the BUS_TIMEOUT-th consecutive one
// BUS_TIMEOUT = 0 removes the counter and expired stays low.
// ---------------------------------------------------------------------------
module ctrl_wait_timer #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    generate
        if (BUS_TIMEOUT == 0) begin : g_disabled
            logic timer_unused;
            assign timer_unused = ^{clk, reset, clear, count};
            assign expired      = 1'b0;
        end else begin : g_enabled
            // The count only has to reach BUS_TIMEOUT-1: expired fires during
            // the wait cycle that would bring it to BUS_TIMEOUT, so the trap
            // is entered on the same edge the limit is reached.
            localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(BUS_TIMEOUT - 1);

            logic [CNT_W-1:0] count_reg;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    count_reg <= '0;
                end else if (count && (count_reg != LIMIT)) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end

            assign expired = count && (count_reg == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Multi-cycle control FSM for the RV32I core. Sequences fetch, decode,
// execute, memory and writeback for each instruction and drives the
// datapath select/enable lines (Moore outputs, qualified by memory ready).
//
// Parameters:
//   BUS_TIMEOUT : max wait cycles on imem_ready/dmem_ready before bus error
//                 (0 disables the timeout)
// Build macro:
//   CTRL_INSTRET_EN : when defined, instret counts cycles with pc_write=1;
//                     otherwise instret is tied to 0.
// Ports:
//   clk, reset      : core clock, synchronous active-high reset
//   opcode, func3   : instruction fields from the parser
//   branch_taken    : comparator result, used in EXECUTE
//   bus             : memory handshakes (ctrl_bus_if.master)
//   ir_load         : latch instruction register
//   pc_write/pc_sel : PC update enable / 0=PC+4, 1=PC+imm
//   alu_src_a/b,op  : ALU operand and operation selects
//   rf_we, wb_sel   : register file write enable / writeback source
//   illegal,bus_err : sticky trap causes
//   instret         : retired instruction count
// All outputs read 0 while reset is high.
// ---------------------------------------------------------------------------
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic              branch_taken,
    ctrl_bus_if.master        bus,
    output logic              ir_load,
    output logic              pc_write,
    output logic              pc_sel,
    output logic [1:0]        alu_src_a,
    output logic              alu_src_b,
    output logic [1:0]        alu_op,
    output logic              rf_we,
    output logic [1:0]        wb_sel,
    output logic              illegal,
    output logic              bus_err,
    output logic [31:0]       instret
);

    state_t state_reg, state_next;
    logic   illegal_reg, bus_err_reg;
    logic   set_illegal, set_bus_err;

    // Un-gated decode results; every output is masked by reset below.
    logic       imem_req_raw, dmem_req_raw, dmem_we_raw;
    logic       ir_load_raw, pc_write_raw, pc_sel_raw;
    logic [1:0] alu_src_a_raw, alu_op_raw, wb_sel_raw;
    logic       alu_src_b_raw, rf_we_raw;

    logic timer_clear, timer_count, timer_expired;

    // func3 is consumed by the ALU decode downstream; the controller itself
    // does not branch on it.
    logic func3_unused;
    assign func3_unused = ^func3;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_FETCH;
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (set_illegal) illegal_reg <= 1'b1;
            if (set_bus_err) bus_err_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        set_illegal   = 1'b0;
        set_bus_err   = 1'b0;
        imem_req_raw  = 1'b0;
        dmem_req_raw  = 1'b0;
        dmem_we_raw   = 1'b0;
        ir_load_raw   = 1'b0;
        pc_write_raw  = 1'b0;
        pc_sel_raw    = 1'b0;
        alu_src_a_raw = SRC_A_RS1;
        alu_src_b_raw = 1'b0;
        alu_op_raw    = ALU_OP_ADD;
        rf_we_raw     = 1'b0;
        wb_sel_raw    = WB_ALU;

        case (state_reg)
            ST_FETCH: begin
                imem_req_raw = 1'b1;
                if (bus.imem_ready) begin
                    ir_load_raw = 1'b1;
                    state_next  = ST_DECODE;
                end else if (timer_expired) begin
                    set_bus_err = 1'b1;
                    state_next  = ST_TRAP;
                end
            end

            ST_DECODE: begin
                if (is_legal_opcode(opcode)) begin
                    state_next = ST_EXECUTE;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = ST_TRAP;
                end
            end

            ST_EXECUTE: begin
                state_next = ST_WRITEBACK;
                case (opcode)
                    OP_R: begin
                        alu_op_raw = ALU_OP_FUNC;
                    end
                    OP_IMM: begin
                        alu_src_b_raw = 1'b1;
                        alu_op_raw    = ALU_OP_FUNC;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b_raw = 1'b1;
                        state_next    = ST_MEM;
                    end
                    OP_LUI: begin
                        alu_src_a_raw = SRC_A_ZERO;
                        alu_src_b_raw = 1'b1;
                    end
                    OP_AUIPC: begin
                        alu_src_a_raw = SRC_A_PC;
                        alu_src_b_raw = 1'b1;
                    end
                    OP_BRANCH: begin
                        alu_op_raw   = ALU_OP_CMP;
                        pc_write_raw = 1'b1;
                        pc_sel_raw   = branch_taken;
                        state_next   = ST_FETCH;
                    end
                    default: begin
                        // JAL: the ALU is idle, target formed in WRITEBACK.
                    end
                endcase
            end

            ST_MEM: begin
                dmem_req_raw = 1'b1;
                dmem_we_raw  = (opcode == OP_STORE);
                if (bus.dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_write_raw = 1'b1;
                        state_next   = ST_FETCH;
                    end else begin
                        state_next = ST_WRITEBACK;
                    end
                end else if (timer_expired) begin
                    set_bus_err = 1'b1;
                    state_next  = ST_TRAP;
                end
            end

            ST_WRITEBACK: begin
                rf_we_raw    = 1'b1;
                pc_write_raw = 1'b1;
                state_next   = ST_FETCH;
                if (opcode == OP_LOAD) begin
                    wb_sel_raw = WB_MEM;
                end else if (opcode == OP_JAL) begin
                    wb_sel_raw = WB_PC4;
                    pc_sel_raw = 1'b1;
                end
            end

            ST_TRAP: begin
                state_next = ST_TRAP;
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Any state change ends the current wait, so the count restarts on every
    // entry to FETCH or MEM (including MEM->FETCH for stores).
    assign timer_clear = (state_next != state_reg);
    assign timer_count = ((state_reg == ST_FETCH) && !bus.imem_ready) ||
                         ((state_reg == ST_MEM)   && !bus.dmem_ready);

    ctrl_wait_timer #(
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .count   (timer_count),
        .expired (timer_expired)
    );

    assign bus.imem_req = imem_req_raw & ~reset;
    assign bus.dmem_req = dmem_req_raw & ~reset;
    assign bus.dmem_we  = dmem_we_raw  & ~reset;
    assign ir_load      = ir_load_raw  & ~reset;
    assign pc_write     = pc_write_raw & ~reset;
    assign pc_sel       = pc_sel_raw   & ~reset;
    assign alu_src_a    = reset ? 2'd0 : alu_src_a_raw;
    assign alu_src_b    = alu_src_b_raw & ~reset;
    assign alu_op       = reset ? 2'd0 : alu_op_raw;
    assign rf_we        = rf_we_raw & ~reset;
    assign wb_sel       = reset ? 2'd0 : wb_sel_raw;
    assign illegal      = illegal_reg & ~reset;
    assign bus_err      = bus_err_reg & ~reset;

`ifdef CTRL_INSTRET_EN
    logic [31:0] instret_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_reg <= '0;
        end else if (pc_write_raw) begin
            instret_reg <= instret_reg + 32'd1;
        end
    end

    assign instret = reset ? 32'd0 : instret_reg;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        branch_taken;
    logic        ir_load, pc_write, pc_sel, alu_src_b, rf_we, illegal, bus_err;
    logic [1:0]  alu_src_a, alu_op, wb_sel;
    logic [31:0] instret;

    ctrl_bus_if bus ();

    multicycle_controller #(.BUS_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .func3        (func3),
        .branch_taken (branch_taken),
        .bus          (bus),
        .ir_load      (ir_load),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef enum int {K_RETIRE, K_ILLEGAL, K_BUSERR, K_ABORT} kind_t;

    typedef struct {
        kind_t kind;
        int    cycles;
        int    imem_cnt;
        int    dmem_cnt;
        int    ir_cnt;
        int    rf_we_cnt;
        int    dmem_we;
        int    pc_sel;
        int    wb_sel;
        int    alu_a;
        int    alu_b;
        int    alu_op;
        int    instret;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ret_cnt  = 0;
    int   txn_id   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: derived from the opcode class, the memory wait counts
    // and the fixed per-class latencies.
    function automatic exp_t model(input logic [6:0] op, input int iw, input int dw,
                                   input bit bt, input bit abort);
        exp_t e;
        bit is_r, is_i, is_ld, is_st, is_br, is_jal, is_lui, is_auipc, legal, mem;
        is_r     = (op == 7'b0110011);
        is_ld    = (op == 7'b0000011);
        is_i     = (op == 7'b0010011);
        is_st    = (op == 7'b0100011);
        is_br    = (op == 7'b1100011);
        is_jal   = (op == 7'b1101111);
        is_lui   = (op == 7'b0110111);
        is_auipc = (op == 7'b0010111);
        legal    = is_r | is_ld | is_i | is_st | is_br | is_jal | is_lui | is_auipc;
        mem      = is_ld | is_st;
        e.kind = K_RETIRE; e.cycles = 0; e.imem_cnt = 0; e.dmem_cnt = 0; e.ir_cnt = 0;
        e.rf_we_cnt = 0; e.dmem_we = 0; e.pc_sel = 0; e.wb_sel = 0;
        e.alu_a = 0; e.alu_b = 0; e.alu_op = 0; e.instret = 0;
        if (iw >= TO) begin
            e.kind = K_BUSERR; e.cycles = TO + 1; return e;
        end
        if (!legal) begin
            e.kind = K_ILLEGAL; e.cycles = iw + 3; return e;
        end
        if (mem && dw >= TO) begin
            e.kind = K_BUSERR; e.cycles = iw + TO + 4; return e;
        end
        if (mem && abort) begin
            e.kind = K_ABORT; e.dmem_cnt = dw; return e;
        end
        e.cycles    = (is_br ? 3 : (is_ld ? 5 : 4)) + iw + (mem ? dw : 0);
        e.imem_cnt  = iw + 1;
        e.ir_cnt    = 1;
        e.dmem_cnt  = mem ? dw + 1 : 0;
        e.dmem_we   = is_st;
        e.rf_we_cnt = (is_br | is_st) ? 0 : 1;
        e.pc_sel    = is_br ? int'(bt) : int'(is_jal);
        e.wb_sel    = is_ld ? 1 : (is_jal ? 2 : 0);
        if (is_r)          begin e.alu_a = 0; e.alu_b = 0; e.alu_op = 1; end
        else if (is_i)     begin e.alu_a = 0; e.alu_b = 1; e.alu_op = 1; end
        else if (mem)      begin e.alu_a = 0; e.alu_b = 1; e.alu_op = 0; end
        else if (is_lui)   begin e.alu_a = 2; e.alu_b = 1; e.alu_op = 0; end
        else if (is_auipc) begin e.alu_a = 1; e.alu_b = 1; e.alu_op = 0; end
        else if (is_br)    begin e.alu_a = 0; e.alu_b = 0; e.alu_op = 2; end
`ifdef CTRL_INSTRET_EN
        e.instret = ret_cnt;
`else
        e.instret = 0;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ready();
        bus.imem_ready = 1'($urandom_range(0, 1));
        bus.dmem_ready = 1'($urandom_range(0, 1));
        branch_taken   = 1'($urandom_range(0, 1));
    endtask

    task automatic trap_hold();
        for (int c = 0; c < 20; c++) begin
            rand_ready();
            tick();
        end
        reset = 1'b1;
        rand_ready();
        tick();
        reset = 1'b0;
        ret_cnt = 0;
    endtask

    // Plays the memories and the instruction parser for one instruction,
    // starting in the first FETCH cycle.
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw,
                             input bit bt, input bit abort);
        exp_t e;
        bit   mem, br;
        e = model(op, iw, dw, bt, abort);
        sb.push_back(e);
        mem = (op == 7'b0000011) || (op == 7'b0100011);
        br  = (op == 7'b1100011);
        if (iw >= TO) begin
            for (int c = 0; c < TO; c++) begin
                rand_ready();
                bus.imem_ready = 1'b0;
                tick();
            end
            trap_hold();
            return;
        end
        for (int c = 0; c <= iw; c++) begin
            rand_ready();
            bus.imem_ready = (c == iw);
            tick();
        end
        opcode = op;
        func3  = 3'($urandom_range(0, 7));
        rand_ready();                       // DECODE
        tick();
        if (e.kind == K_ILLEGAL) begin
            trap_hold();
            return;
        end
        rand_ready();                       // EXECUTE
        branch_taken = bt;
        tick();
        if (br) begin
            ret_cnt++;
            return;
        end
        if (mem) begin
            if (dw >= TO) begin
                for (int c = 0; c < TO; c++) begin
                    rand_ready();
                    bus.dmem_ready = 1'b0;
                    tick();
                end
                trap_hold();
                return;
            end
            for (int c = 0; c <= dw; c++) begin
                rand_ready();
                bus.dmem_ready = (c == dw);
                if (c == dw && abort) reset = 1'b1;
                tick();
            end
            if (abort) begin
                reset = 1'b0;
                ret_cnt = 0;
                return;
            end
            if (op == 7'b0100011) begin
                ret_cnt++;
                return;
            end
        end
        rand_ready();                       // WRITEBACK
        tick();
        ret_cnt++;
    endtask

    // Monitor: measures each instruction from the DUT outputs and compares it
    // against the oldest scoreboard entry when it retires, traps or aborts.
    int m_cyc, m_imem, m_dmem, m_ir, m_rf, m_dwe, m_wb, m_exec_at;
    int m_a, m_b, m_op;
    bit m_in_trap;

    task automatic m_clear();
        m_cyc = 0; m_imem = 0; m_dmem = 0; m_ir = 0; m_rf = 0; m_dwe = 0;
        m_wb = 0; m_exec_at = -1; m_a = 0; m_b = 0; m_op = 0;
    endtask

    initial begin : monitor
        exp_t e;
        kind_t act_kind;
        m_clear();
        m_in_trap = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("reset_ctrl", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, ir_load,
                      pc_write, pc_sel, alu_src_a, alu_src_b, alu_op, rf_we, wb_sel,
                      illegal, bus_err}), 32'd0);
                check("reset_instret", instret, 32'd0);
                if (m_cyc > 0 && sb.size() > 0 && sb[0].kind == K_ABORT) begin
                    e = sb.pop_front();
                    txn_id++;
                    check("abort_rf_we", m_rf, 0);
                    check("abort_dmem_req", m_dmem, e.dmem_cnt);
                    $display("txn %0d: ABORT by reset after %0d cycles", txn_id, m_cyc);
                end
                m_clear();
                m_in_trap = 1'b0;
            end else if (m_in_trap) begin
                check("trap_quiet", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, ir_load,
                      pc_write, rf_we, illegal | bus_err}), 32'd1);
            end else begin
                m_cyc++;
                m_imem += int'(bus.imem_req);
                m_dmem += int'(bus.dmem_req);
                m_ir   += int'(ir_load);
                m_rf   += int'(rf_we);
                if (bus.dmem_we) m_dwe = 1;
                if (rf_we) m_wb = int'(wb_sel);
                if (bus.imem_req && bus.dmem_req) check("req_overlap", 32'd1, 32'd0);
                if (m_cyc == m_exec_at) begin
                    m_a = int'(alu_src_a); m_b = int'(alu_src_b); m_op = int'(alu_op);
                end
                if (ir_load) m_exec_at = m_cyc + 2;
                if (pc_write) begin
                    txn_id++;
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_pc_write: got 1, expected 0 (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("kind", K_RETIRE, e.kind);
                        check("latency", m_cyc, e.cycles);
                        check("imem_req_cycles", m_imem, e.imem_cnt);
                        check("ir_load_cycles", m_ir, e.ir_cnt);
                        check("dmem_req_cycles", m_dmem, e.dmem_cnt);
                        check("dmem_we", m_dwe, e.dmem_we);
                        check("rf_we_cycles", m_rf, e.rf_we_cnt);
                        check("pc_sel", 32'(pc_sel), e.pc_sel);
                        check("wb_sel", m_wb, e.wb_sel);
                        check("alu_src_a", m_a, e.alu_a);
                        check("alu_src_b", m_b, e.alu_b);
                        check("alu_op", m_op, e.alu_op);
                        check("instret", instret, e.instret);
                        $display("txn %0d: RETIRE in %0d cycles pc_sel=%0d rf_we=%0d wb_sel=%0d",
                                 txn_id, m_cyc, pc_sel, m_rf, m_wb);
                    end
                    m_clear();
                end else if (illegal || bus_err) begin
                    txn_id++;
                    act_kind = illegal ? K_ILLEGAL : K_BUSERR;
                    if (illegal && bus_err) act_kind = K_RETIRE;
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_trap: got kind %0d, expected none (t=%0t)",
                                 act_kind, $time);
                    end else begin
                        e = sb.pop_front();
                        check("trap_kind", act_kind, e.kind);
                        check("trap_latency", m_cyc, e.cycles);
                    end
                    $display("txn %0d: TRAP illegal=%0d bus_err=%0d after %0d cycles",
                             txn_id, illegal, bus_err, m_cyc);
                    m_clear();
                    m_in_trap = 1'b1;
                end else if (m_cyc > 200) begin
                    n_checks++; n_fail++;
                    $display("FAIL watchdog: got %0d idle cycles, expected at most 200", m_cyc);
                    m_clear();
                end
            end
        end
    end

    logic [6:0] legal_ops [8];

    initial begin : driver
        logic [6:0] op;
        int iw, dw;
        legal_ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011,
                      7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
        opcode = 7'd0; func3 = 3'd0; branch_taken = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        ret_cnt = 0;

        run_instr(7'b0110011, 0, 0, 1'b0, 1'b0);   // R-type 0x002081B3
        run_instr(7'b0000011, 0, 3, 1'b0, 1'b0);   // load, dmem_ready after 3 waits
        run_instr(7'b1100011, 0, 0, 1'b1, 1'b0);   // branch taken
        run_instr(7'b1100011, 0, 0, 1'b0, 1'b0);   // branch not taken
        run_instr(7'b0100011, 2, 1, 1'b0, 1'b0);   // store with waits
        run_instr(7'b0000000, 0, 0, 1'b0, 1'b0);   // illegal -> trap, reset
        run_instr(7'b0110011, TO, 0, 1'b0, 1'b0);  // imem timeout -> bus_err
        for (int i = 0; i < 10; i++)
            run_instr(legal_ops[$urandom_range(0, 7)], 0, 0, 1'($urandom_range(0, 1)), 1'b0);
`ifdef CTRL_INSTRET_EN
        check("instret_after_10", instret, 32'd10);
`else
        check("instret_after_10", instret, 32'd0);
`endif
        run_instr(7'b0100011, 1, 2, 1'b0, 1'b1);   // reset during store completion
        run_instr(7'b0000011, 0, 0, 1'b0, 1'b1);   // reset during load completion
        run_instr(7'b1101111, 3, 0, 1'b0, 1'b0);   // JAL, longest legal fetch wait
        run_instr(7'b0000011, 0, TO, 1'b0, 1'b0);  // dmem timeout -> bus_err

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 11) == 0) op = 7'($urandom_range(0, 127));
            else                            op = legal_ops[$urandom_range(0, 7)];
            iw = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, 3);
            dw = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, 3);
            run_instr(op, iw, dw, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

`ifdef CTRL_INSTRET_EN
        check("final_instret", instret, ret_cnt);
`else
        check("final_instret", instret, 32'd0);
`endif
        check("scoreboard_empty", sb.size(), 0);
        reset = 1'b1;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
